branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits directly downstream of the ALU comparator.
- Consumes the comparator's 4-bit condition flags together with the decoded branch/jump/trap operation, current PC and immediate.
- Resolves the operation into three outputs:
  - a PC redirect that honours the MIPS branch delay slot;
  - an optional link-register write;
  - a trap request held under a req/ack handshake with the exception controller.
- Registered, FSM-based; stalls upstream issue while a trap is outstanding.

Parameters:
- ADDR_W, 32, PC/target width; fixed at 32 in this design.
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  an operation is presented this cycle.
- brOp  in  4  operation code; encodings in shared package.
- condFlag  in  4  comparator flags: [0] condition true, [2] signed compare true, [3] unsigned compare true; [1] ignored.
- pc  in  32  PC of the presented instruction.
- imm26  in  26  jump index; bits [15:0] are the branch offset.
- slotValid  in  1  delay-slot instruction issued this cycle.
- trapAck  in  1  exception controller accepted the trap.
- ready  out  1  block accepts valid this cycle.
- redirect  out  1  one-cycle pulse: fetch must load targetPc.
- targetPc  out  32  resolved target; held stable while redirect=1.
- linkWrite  out  1  one-cycle pulse: write linkValue to $31.
- linkValue  out  32  pc+8 of the linking instruction.
- trapReq  out  1  trap pending.
- trapPc  out  32  PC of the trapping instruction.

Behaviour:
- Reset: all outputs 0 except ready=1; state IDLE; internal registers 0. Reset mid-operation aborts everything, with no redirect or trapReq afterwards. Reset beats a simultaneous trapAck.
- States: IDLE, DELAY, REDIRECT, TRAP_WAIT. ready=1 in IDLE and DELAY only.
- brOp encodings:
  - 0 NONE, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGEZAL, 5 BLTZ, 6 BLTZAL, 7 BGTZ, 8 BLEZ, 9 J, 10 JAL;
  - 11 TEQ, 12 TNE, 13 TSGN (TGE/TLT), 14 TUNS (TGEU/TLTU);
  - 15 reserved, treated as NONE.
- Taken condition:
  - branches 1-8, TEQ and TNE use condFlag[0];
  - J and JAL are always taken;
  - TSGN uses condFlag[2];
  - TUNS uses condFlag[3].
- Target arithmetic, mod 2^32 (wrap-around is silent):
  - branch target = pc+4+(sign-extend(imm26[15:0])<<2);
  - jump target = {(pc+4)[31:28], imm26, 2'b00}.
- IDLE, valid=1 sampled at cycle N:
  - taken branch or jump: latch target; state DELAY at N+1.
  - taken trap: trapReq=1 and trapPc=pc from N+1; state TRAP_WAIT.
  - not taken, or NONE: stay IDLE; no outputs.
- Link write: BGEZAL, BLTZAL and JAL pulse linkWrite at N+1 with linkValue=pc+8, whether taken or not.
- DELAY: waits any number of cycles for slotValid.
  - On slotValid at cycle M: state REDIRECT; redirect=1 and targetPc valid during cycle M+1 only; then IDLE.
  - valid while in DELAY is the delay-slot instruction: its link write and trap are processed as in IDLE, but a branch or jump in the slot is ignored (architecturally undefined).
  - A trap in the slot takes priority: the pending redirect is discarded and the state goes to TRAP_WAIT.
- TRAP_WAIT:
  - trapReq holds until trapAck is sampled high; trapReq=0 in the next cycle; state IDLE.
  - valid is ignored (ready=0).
  - trapAck outside TRAP_WAIT is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined, adds output ports statTaken, statNotTaken and statTraps (each STAT_W wide). Each counts accepted branch/jump (taken), branch (not taken) and trap (taken) events, saturates at all-ones, and is cleared by reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: brOp encoding constants, condFlag bit-index constants, FSM state encoding.
- One natural sub-module, branch_target_calc: combinational target and pc+8 computation, instantiated once.

Test Plan:
- BEQ, pc=0x00400000, imm=0x0004, condFlag=0001 → DELAY; slotValid two cycles later → redirect=1 one cycle, targetPc=0x00400014.
- BLTZAL not taken, pc=0x100, condFlag=0000 → linkWrite=1, linkValue=0x108, no redirect, ready stays 1.
- TUNS with condFlag=1000, pc=0x200 → trapReq=1, trapPc=0x200, ready=0; trapAck after 3 cycles → trapReq=0 next cycle, IDLE.
- Negative offset imm=0xFFFF at pc=0x0 → targetPc=0x00000000; J with imm26=0x3FFFFFF, pc=0xF0000000 → targetPc=0xFFFFFFFC.
- Taken BNE then TEQ taken in the delay slot → no redirect, trapReq=1 with the slot PC.
- Reset asserted during DELAY and during TRAP_WAIT → all outputs 0 immediately, ready=1, no later redirect; stats counters (if enabled) = 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for branch_resolver: operation encodings, condition
// flag bit positions, FSM state encoding and operation decode helpers.
package branch_resolver_pkg;

  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_BEQ    = 4'd1,
    OP_BNE    = 4'd2,
    OP_BGEZ   = 4'd3,
    OP_BGEZAL = 4'd4,
    OP_BLTZ   = 4'd5,
    OP_BLTZAL = 4'd6,
    OP_BGTZ   = 4'd7,
    OP_BLEZ   = 4'd8,
    OP_J      = 4'd9,
    OP_JAL    = 4'd10,
    OP_TEQ    = 4'd11,
    OP_TNE    = 4'd12,
    OP_TSGN   = 4'd13,
    OP_TUNS   = 4'd14,
    OP_RSVD   = 4'd15
  } br_op_e;

  // Comparator flag bit positions; bit 1 carries nothing used here.
  localparam int unsigned CF_COND     = 0;
  localparam int unsigned CF_SIGNED   = 2;
  localparam int unsigned CF_UNSIGNED = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DELAY     = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_TRAP_WAIT = 2'd3
  } state_e;

  // Conditional PC-relative branches (BEQ..BLEZ).
  function automatic logic is_branch(input br_op_e op);
    return (op >= OP_BEQ) && (op <= OP_BLEZ);
  endfunction

  function automatic logic is_jump(input br_op_e op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_trap(input br_op_e op);
    return (op >= OP_TEQ) && (op <= OP_TUNS);
  endfunction

  function automatic logic is_link(input br_op_e op);
    return (op == OP_BGEZAL) || (op == OP_BLTZAL) || (op == OP_JAL);
  endfunction

  // Whether the operation's condition holds for the given comparator flags.
  function automatic logic cond_taken(input br_op_e op, input logic [3:0] flags);
    logic t;
    t = 1'b0;
    if (is_branch(op) || (op == OP_TEQ) || (op == OP_TNE)) t = flags[CF_COND];
    else if (is_jump(op))                                   t = 1'b1;
    else if (op == OP_TSGN)                                 t = flags[CF_SIGNED];
    else if (op == OP_TUNS)                                 t = flags[CF_UNSIGNED];
    return t;
  endfunction

endpackage

// File: rtl/branch_resolver_target_calc.sv
// branch_target_calc: combinational branch/jump target and link value.
// All arithmetic is modulo 2^32; overflow wraps silently.
module branch_target_calc (
  input  logic [31:0] pc_i,
  input  logic [25:0] imm26_i,
  input  logic        is_jump_i,
  output logic [31:0] target_o,
  output logic [31:0] link_value_o
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  // Select PC-relative or pseudo-absolute target; link is always pc+8.
  always_comb begin
    pc4          = pc_i + 32'd4;
    br_off       = {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};
    target_o     = is_jump_i ? {pc4[31:28], imm26_i, 2'b00} : (pc4 + br_off);
    link_value_o = pc_i + 32'd8;
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: turns comparator flags plus a decoded branch/jump/trap
// operation into a delay-slot-aware PC redirect, a link-register write and a
// trap request held under req/ack. All outputs are registered.
// Optional statistics counters are compiled in with BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  parameter int unsigned STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [3:0]        brOp,
  input  logic [3:0]        condFlag,
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       imm26,
  input  logic              slotValid,
  input  logic              trapAck,
  output logic              ready,
  output logic              redirect,
  output logic [ADDR_W-1:0] targetPc,
  output logic              linkWrite,
  output logic [ADDR_W-1:0] linkValue,
  output logic              trapReq,
  output logic [ADDR_W-1:0] trapPc
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [STAT_W-1:0] statTaken,
  output logic [STAT_W-1:0] statNotTaken,
  output logic [STAT_W-1:0] statTraps
`endif
);

  state_e            state_q;
  logic              ready_q;
  logic              redirect_q;
  logic [ADDR_W-1:0] targetPc_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              linkWrite_q;
  logic [ADDR_W-1:0] linkValue_q;
  logic              trapReq_q;
  logic [ADDR_W-1:0] trapPc_q;

  br_op_e      op;
  logic        cond;
  logic        ctrl_taken;
  logic        trap_taken;
  logic        nt_branch;
  logic        link_op;
  logic        accept;
  logic [31:0] calc_target;
  logic [31:0] calc_link;

  branch_target_calc u_calc (
    .pc_i         (pc),
    .imm26_i      (imm26),
    .is_jump_i    (is_jump(op)),
    .target_o     (calc_target),
    .link_value_o (calc_link)
  );

  // Decode the presented operation against the comparator flags.
  always_comb begin
    op         = br_op_e'(brOp);
    cond       = cond_taken(op, condFlag);
    ctrl_taken = (is_branch(op) || is_jump(op)) && cond;
    trap_taken = is_trap(op) && cond;
    nt_branch  = is_branch(op) && !cond;
    link_op    = is_link(op);
    accept     = valid && ((state_q == ST_IDLE) || (state_q == ST_DELAY));
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      redirect_q  <= 1'b0;
      targetPc_q  <= '0;
      tgt_q       <= '0;
      linkWrite_q <= 1'b0;
      linkValue_q <= '0;
      trapReq_q   <= 1'b0;
      trapPc_q    <= '0;
    end else begin
      redirect_q  <= 1'b0;
      targetPc_q  <= '0;
      linkWrite_q <= 1'b0;
      linkValue_q <= '0;
      unique case (state_q)
        ST_IDLE, ST_DELAY: begin
          if (accept && link_op) begin
            linkWrite_q <= 1'b1;
            linkValue_q <= calc_link;
          end
          // A trap (including one in the delay slot) wins over any pending
          // redirect; a branch presented while in DELAY is ignored.
          if (accept && trap_taken) begin
            state_q   <= ST_TRAP_WAIT;
            ready_q   <= 1'b0;
            trapReq_q <= 1'b1;
            trapPc_q  <= pc;
            tgt_q     <= '0;
          end else if (state_q == ST_IDLE) begin
            if (accept && ctrl_taken) begin
              state_q <= ST_DELAY;
              tgt_q   <= calc_target;
            end
          end else if (slotValid) begin
            state_q    <= ST_REDIRECT;
            ready_q    <= 1'b0;
            redirect_q <= 1'b1;
            targetPc_q <= tgt_q;
          end
        end
        ST_REDIRECT: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          tgt_q   <= '0;
        end
        ST_TRAP_WAIT: begin
          if (trapAck) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            trapReq_q <= 1'b0;
            trapPc_q  <= '0;
          end
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign redirect  = redirect_q;
  assign targetPc  = targetPc_q;
  assign linkWrite = linkWrite_q;
  assign linkValue = linkValue_q;
  assign trapReq   = trapReq_q;
  assign trapPc    = trapPc_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [STAT_W-1:0] statTaken_q;
  logic [STAT_W-1:0] statNotTaken_q;
  logic [STAT_W-1:0] statTraps_q;
  logic              ev_taken;
  logic              ev_not_taken;
  logic              ev_trap;

  // Event strobes: only IDLE accepts branches; traps count in IDLE or DELAY.
  always_comb begin
    ev_taken     = accept && (state_q == ST_IDLE) && ctrl_taken;
    ev_not_taken = accept && (state_q == ST_IDLE) && nt_branch;
    ev_trap      = accept && trap_taken;
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statTaken_q    <= '0;
      statNotTaken_q <= '0;
      statTraps_q    <= '0;
    end else begin
      if (ev_taken && (statTaken_q != '1))       statTaken_q    <= statTaken_q + STAT_W'(1);
      if (ev_not_taken && (statNotTaken_q != '1)) statNotTaken_q <= statNotTaken_q + STAT_W'(1);
      if (ev_trap && (statTraps_q != '1))        statTraps_q    <= statTraps_q + STAT_W'(1);
    end
  end

  assign statTaken    = statTaken_q;
  assign statNotTaken = statNotTaken_q;
  assign statTraps    = statTraps_q;
`else
  logic unused_nt;
  assign unused_nt = nt_branch;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: table of single operations issued
// from IDLE plus hand-written delay-slot, trap-handshake and reset sequences.
module tb_branch_resolver;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [3:0]  brOp;
  logic [3:0]  condFlag;
  logic [31:0] pc;
  logic [25:0] imm26;
  logic        slotValid;
  logic        trapAck;
  logic        ready;
  logic        redirect;
  logic [31:0] targetPc;
  logic        linkWrite;
  logic [31:0] linkValue;
  logic        trapReq;
  logic [31:0] trapPc;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] statTaken;
  logic [31:0] statNotTaken;
  logic [31:0] statTraps;
`endif

  branch_resolver #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .brOp      (brOp),
    .condFlag  (condFlag),
    .pc        (pc),
    .imm26     (imm26),
    .slotValid (slotValid),
    .trapAck   (trapAck),
    .ready     (ready),
    .redirect  (redirect),
    .targetPc  (targetPc),
    .linkWrite (linkWrite),
    .linkValue (linkValue),
    .trapReq   (trapReq),
    .trapPc    (trapPc)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .statTaken    (statTaken),
    .statNotTaken (statNotTaken),
    .statTraps    (statTraps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [3:0]  cf;
    logic [31:0] pc;
    logic [25:0] imm;
    bit          lnk;
    logic [31:0] lv;
    bit          dly;
    logic [31:0] tgt;
    bit          trp;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op, input logic [3:0] cf,
                              input logic [31:0] p, input logic [25:0] im,
                              input bit lnk, input bit dly, input logic [31:0] tgt, input bit trp);
    vec_t v;
    v.name = nm; v.op = op; v.cf = cf; v.pc = p; v.imm = im;
    v.lnk = lnk; v.lv = p + 32'd8; v.dly = dly; v.tgt = tgt; v.trp = trp;
    return v;
  endfunction

  // Redirect must be a single-cycle pulse.
  logic prev_redirect = 1'b0;
  always @(negedge clk) begin
    if (redirect) chk("redirect_one_cycle", {31'd0, prev_redirect}, 32'd0);
    prev_redirect <= redirect;
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] cf,
                       input logic [31:0] p, input logic [25:0] im, input logic slot);
    valid = 1'b1; brOp = op; condFlag = cf; pc = p; imm26 = im; slotValid = slot;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; brOp = 4'd0; condFlag = 4'd0; pc = '0; imm26 = '0; slotValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    issue(v.op, v.cf, v.pc, v.imm, 1'b0);
    exp_q.push_back(v);
    @(negedge clk);
    idle_inputs();
    e = exp_q.pop_front();
    chk({e.name, ".linkWrite"}, {31'd0, linkWrite}, {31'd0, e.lnk});
    if (e.lnk) chk({e.name, ".linkValue"}, linkValue, e.lv);
    chk({e.name, ".trapReq"}, {31'd0, trapReq}, {31'd0, e.trp});
    if (e.trp) chk({e.name, ".trapPc"}, trapPc, e.pc);
    chk({e.name, ".ready"}, {31'd0, ready}, {31'd0, !e.trp});
    chk({e.name, ".redirect0"}, {31'd0, redirect}, 32'd0);
    if (e.dly) begin
      slotValid = 1'b1;
      @(negedge clk);
      slotValid = 1'b0;
      chk({e.name, ".redirect"}, {31'd0, redirect}, 32'd1);
      chk({e.name, ".targetPc"}, targetPc, e.tgt);
      chk({e.name, ".ready_redir"}, {31'd0, ready}, 32'd0);
      chk({e.name, ".linkPulse"}, {31'd0, linkWrite}, 32'd0);
    end else if (e.trp) begin
      trapAck = 1'b1;
      @(negedge clk);
      trapAck = 1'b0;
      chk({e.name, ".trapDrop"}, {31'd0, trapReq}, 32'd0);
    end else begin
      @(negedge clk);
      chk({e.name, ".linkPulse"}, {31'd0, linkWrite}, 32'd0);
      chk({e.name, ".noRedirect"}, {31'd0, redirect}, 32'd0);
    end
    @(negedge clk);
    chk({e.name, ".backIdle"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; trapAck = 1'b0;
    idle_inputs();

    //            name       op     cf       pc            imm          lnk dly tgt           trp
    tv.push_back(mk("beq_t",   4'd1,  4'b0001, 32'h00400000, 26'h0000004, 0, 1, 32'h00400014, 0));
    tv.push_back(mk("bltzal_n",4'd6,  4'b0000, 32'h00000100, 26'h0000010, 1, 0, 32'h0,        0));
    tv.push_back(mk("bgezal_t",4'd4,  4'b0001, 32'h00000200, 26'h0000010, 1, 1, 32'h00000244, 0));
    tv.push_back(mk("beq_neg", 4'd1,  4'b0001, 32'h00000000, 26'h000FFFF, 0, 1, 32'h00000000, 0));
    tv.push_back(mk("j_max",   4'd9,  4'b0000, 32'hF0000000, 26'h3FFFFFF, 0, 1, 32'hFFFFFFFC, 0));
    tv.push_back(mk("jal",     4'd10, 4'b0000, 32'h00400010, 26'h0100000, 1, 1, 32'h00400000, 0));
    tv.push_back(mk("bne_n",   4'd2,  4'b1110, 32'h00000040, 26'h0000001, 0, 0, 32'h0,        0));
    tv.push_back(mk("bgtz_neg",4'd7,  4'b0011, 32'h00000010, 26'h0008000, 0, 1, 32'hFFFE0014, 0));
    tv.push_back(mk("blez_wr", 4'd8,  4'b0001, 32'h7FFFFFFC, 26'h0000001, 0, 1, 32'h80000004, 0));
    tv.push_back(mk("bltz_b1", 4'd5,  4'b0010, 32'h00000050, 26'h0000001, 0, 0, 32'h0,        0));
    tv.push_back(mk("teq_t",   4'd11, 4'b0001, 32'h00000300, 26'h0,       0, 0, 32'h0,        1));
    tv.push_back(mk("tne_n",   4'd12, 4'b0000, 32'h00000304, 26'h0,       0, 0, 32'h0,        0));
    tv.push_back(mk("tsgn_t",  4'd13, 4'b0100, 32'h00000400, 26'h0,       0, 0, 32'h0,        1));
    tv.push_back(mk("tsgn_n",  4'd13, 4'b1011, 32'h00000404, 26'h0,       0, 0, 32'h0,        0));
    tv.push_back(mk("tuns_n",  4'd14, 4'b0111, 32'h00000408, 26'h0,       0, 0, 32'h0,        0));
    tv.push_back(mk("none",    4'd0,  4'b1111, 32'h00000500, 26'h0,       0, 0, 32'h0,        0));
    tv.push_back(mk("rsvd",    4'd15, 4'b1111, 32'h00000504, 26'h0,       0, 0, 32'h0,        0));

    // Reset state.
    #12;
    chk("rst.ready", {31'd0, ready}, 32'd1);
    chk("rst.redirect", {31'd0, redirect}, 32'd0);
    chk("rst.trapReq", {31'd0, trapReq}, 32'd0);
    chk("rst.linkWrite", {31'd0, linkWrite}, 32'd0);
    chk("rst.targetPc", targetPc, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) run_vec(tv[i]);

    // BEQ with slotValid two cycles later.
    @(negedge clk);
    issue(4'd1, 4'b0001, 32'h00400000, 26'h0000004, 1'b0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("beq_wait.ready", {31'd0, ready}, 32'd1);
    chk("beq_wait.redirect", {31'd0, redirect}, 32'd0);
    slotValid = 1'b1;
    @(negedge clk);
    slotValid = 1'b0;
    chk("beq_wait.redirect1", {31'd0, redirect}, 32'd1);
    chk("beq_wait.targetPc", targetPc, 32'h00400014);
    @(negedge clk);
    chk("beq_wait.redirect_end", {31'd0, redirect}, 32'd0);

    // TUNS trap, ack after 3 cycles; valid ignored while waiting.
    @(negedge clk);
    issue(4'd14, 4'b1000, 32'h00000200, 26'h0, 1'b0);
    @(negedge clk);
    issue(4'd11, 4'b0001, 32'h00000999, 26'h0, 1'b0);
    chk("tuns.trapReq", {31'd0, trapReq}, 32'd1);
    chk("tuns.trapPc", trapPc, 32'h00000200);
    chk("tuns.ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    chk("tuns.hold", {31'd0, trapReq}, 32'd1);
    chk("tuns.holdPc", trapPc, 32'h00000200);
    trapAck = 1'b1;
    @(negedge clk);
    trapAck = 1'b0;
    chk("tuns.drop", {31'd0, trapReq}, 32'd0);
    chk("tuns.ready_back", {31'd0, ready}, 32'd1);
    // Stray ack in IDLE must not produce anything.
    trapAck = 1'b1;
    @(negedge clk);
    trapAck = 1'b0;
    chk("stray_ack.trapReq", {31'd0, trapReq}, 32'd0);

    // Taken BNE, then TEQ taken in the delay slot.
    @(negedge clk);
    issue(4'd2, 4'b0001, 32'h00001000, 26'h0000020, 1'b0);
    @(negedge clk);
    issue(4'd11, 4'b0001, 32'h00001004, 26'h0, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("slot_trap.trapReq", {31'd0, trapReq}, 32'd1);
    chk("slot_trap.trapPc", trapPc, 32'h00001004);
    chk("slot_trap.redirect", {31'd0, redirect}, 32'd0);
    trapAck = 1'b1;
    @(negedge clk);
    trapAck = 1'b0;
    chk("slot_trap.redirect2", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    chk("slot_trap.redirect3", {31'd0, redirect}, 32'd0);

    // Branch in the delay slot is ignored; the JAL link in the slot still fires.
    @(negedge clk);
    issue(4'd1, 4'b0001, 32'h00002000, 26'h0000001, 1'b0);
    @(negedge clk);
    issue(4'd10, 4'b0000, 32'h00002004, 26'h0000123, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("slot_jal.redirect", {31'd0, redirect}, 32'd1);
    chk("slot_jal.targetPc", targetPc, 32'h00002008);
    chk("slot_jal.linkWrite", {31'd0, linkWrite}, 32'd1);
    chk("slot_jal.linkValue", linkValue, 32'h0000200C);
    @(negedge clk);
    chk("slot_jal.ready", {31'd0, ready}, 32'd1);

    // Reset during DELAY: no redirect afterwards.
    @(negedge clk);
    issue(4'd9, 4'b0000, 32'h00003000, 26'h0000040, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("rst_delay.ready", {31'd0, ready}, 32'd1);
    chk("rst_delay.redirect", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    slotValid = 1'b1;
    @(negedge clk);
    slotValid = 1'b0;
    chk("rst_delay.noRedirect", {31'd0, redirect}, 32'd0);
    chk("rst_delay.targetPc", targetPc, 32'd0);

    // Reset during TRAP_WAIT, together with trapAck.
    @(negedge clk);
    issue(4'd12, 4'b0001, 32'h00004000, 26'h0, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("rst_trap.pre", {31'd0, trapReq}, 32'd1);
    #2 reset = 1'b1; trapAck = 1'b1;
    #1;
    chk("rst_trap.trapReq", {31'd0, trapReq}, 32'd0);
    chk("rst_trap.trapPc", trapPc, 32'd0);
    chk("rst_trap.ready", {31'd0, ready}, 32'd1);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("rst_trap.statTaken", statTaken, 32'd0);
    chk("rst_trap.statNotTaken", statNotTaken, 32'd0);
    chk("rst_trap.statTraps", statTraps, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0; trapAck = 1'b0;
    @(negedge clk);
    chk("rst_trap.after", {31'd0, trapReq}, 32'd0);
    chk("rst_trap.redirect", {31'd0, redirect}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
